// File: rtl/csr_arb_pkg.sv
`default_nettype none
//============================================================================
// Module : csr_arb_pkg
// Desc   : Shared types and defaults for the CSR i/o arbiter.
// Rev    : 1.0  initial release
//============================================================================
package csr_arb_pkg;

    localparam int c_default_aw = 16;
    localparam int c_default_dw = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ACK    = 2'b10
    } state_e;

    // Owner index: 0 = J1 core, 1 = auxiliary master.
    typedef logic owner_t;
    localparam owner_t c_owner_core = 1'b0;
    localparam owner_t c_owner_aux  = 1'b1;

endpackage : csr_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
//============================================================================
// Module : rr_arb2
// Desc   : Combinational two-input round-robin pick with lock override.
// Rev    : 1.0  initial release
//============================================================================
module rr_arb2
    import csr_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    input  logic       lock_hold,
    output owner_t     winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = last_owner;
        if (lock_hold && req[last_owner]) begin
            winner = last_owner;
        end else if (req == 2'b11) begin
            winner = ~last_owner;
        end else if (req[1]) begin
            winner = c_owner_aux;
        end else begin
            winner = c_owner_core;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/csr_io_arbiter.sv
`default_nettype none
//============================================================================
// Module : csr_io_arbiter
// Desc   : Two-master request/ack sequencer for the CSR strobe port.
// Rev    : 1.0  initial release
//============================================================================
module csr_io_arbiter
    import csr_arb_pkg::*;
#(
    parameter int AW = c_default_aw,
    parameter int DW = c_default_dw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] csr_addr,
    output logic [DW-1:0] csr_wdata,
    output logic          csr_wr,
    output logic          csr_rd,
    input  logic [DW-1:0] csr_rdata
);

    state_e        r_state;
    state_e        w_next_state;
    owner_t        r_last_owner;
    logic          r_lock_hold;
    logic          r_we;
    logic [AW-1:0] r_csr_addr;
    logic [DW-1:0] r_csr_wdata;
    logic          r_csr_wr;
    logic          r_csr_rd;
    logic          r_m0_ack;
    logic          r_m1_ack;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;

    logic [1:0]    w_req;
    owner_t        w_winner;
    logic          w_valid;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    assign w_req = {m1_req, m0_req};

    rr_arb2 u_rr_arb2 (
        .req        (w_req),
        .last_owner (r_last_owner),
        .lock_hold  (r_lock_hold),
        .winner     (w_winner),
        .valid      (w_valid)
    );

    always_comb begin
        w_sel_we    = m0_we;
        w_sel_addr  = m0_addr;
        w_sel_wdata = m0_wdata;
        if (w_winner == c_owner_aux) begin
            w_sel_we    = m1_we;
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_next_state = ACCESS;
            ACCESS:  w_next_state = ACK;
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The current owner is always last_owner once a grant has been made.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_owner <= c_owner_aux;
            r_lock_hold  <= 1'b0;
            r_we         <= 1'b0;
            r_csr_addr   <= '0;
            r_csr_wdata  <= '0;
            r_csr_wr     <= 1'b0;
            r_csr_rd     <= 1'b0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            r_csr_wr <= 1'b0;
            r_csr_rd <= 1'b0;
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_lock_hold && !w_req[r_last_owner]) begin
                        r_lock_hold <= 1'b0;
                    end
                    if (w_valid) begin
                        r_last_owner <= w_winner;
                        r_we         <= w_sel_we;
                        r_csr_addr   <= w_sel_addr;
                        r_csr_wdata  <= w_sel_wdata;
                        r_csr_wr     <= w_sel_we;
                        r_csr_rd     <= ~w_sel_we;
                    end
                end
                ACCESS: begin
                    if (r_last_owner == c_owner_aux) begin
                        r_m1_ack <= 1'b1;
                        if (!r_we) r_m1_rdata <= csr_rdata;
                    end else begin
                        r_m0_ack <= 1'b1;
                        if (!r_we) r_m0_rdata <= csr_rdata;
                    end
                end
                ACK: begin
                    r_lock_hold <= (r_last_owner == c_owner_aux) ? m1_lock : m0_lock;
                end
                default: begin
                end
            endcase
        end
    end

    assign csr_addr  = r_csr_addr;
    assign csr_wdata = r_csr_wdata;
    assign csr_wr    = r_csr_wr;
    assign csr_rd    = r_csr_rd;
    assign m0_ack    = r_m0_ack;
    assign m1_ack    = r_m1_ack;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;

endmodule : csr_io_arbiter
`default_nettype wire

// File: tb/tb_csr_io_arbiter.sv
`default_nettype none
//============================================================================
// Module : tb_csr_io_arbiter
// Desc   : Directed self-checking bench for csr_io_arbiter.
// Rev    : 1.0  initial release
//============================================================================
module tb_csr_io_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock;
    logic [15:0] m0_addr, m0_wdata;
    logic        m0_ack;
    logic [15:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [15:0] m1_addr, m1_wdata;
    logic        m1_ack;
    logic [15:0] m1_rdata;
    logic [15:0] csr_addr, csr_wdata, csr_rdata;
    logic        csr_wr, csr_rd;

    int n_cmp  = 0;
    int n_fail = 0;

    csr_io_arbiter #(.AW(16), .DW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_wr    (csr_wr),
        .csr_rd    (csr_rd),
        .csr_rdata (csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
        csr_rdata = 16'h0000;
        step(); step();
        chk1 ("rst_m0_ack",   m0_ack,   1'b0);
        chk1 ("rst_m1_ack",   m1_ack,   1'b0);
        chk1 ("rst_csr_wr",   csr_wr,   1'b0);
        chk1 ("rst_csr_rd",   csr_rd,   1'b0);
        chk16("rst_csr_addr", csr_addr, 16'h0000);
        chk16("rst_m0_rdata", m0_rdata, 16'h0000);
        chk16("rst_m1_rdata", m1_rdata, 16'h0000);
        rst_n = 1'b1;
        step();

        // single write from m0
        m0_req = 1; m0_we = 1; m0_addr = 16'h0010; m0_wdata = 16'h00A5;
        #1;
        chk1 ("wr_no_comb_path", csr_wr, 1'b0);
        step();
        chk1 ("wr_strobe",    csr_wr,    1'b1);
        chk1 ("wr_no_rd",     csr_rd,    1'b0);
        chk16("wr_addr",      csr_addr,  16'h0010);
        chk16("wr_wdata",     csr_wdata, 16'h00A5);
        chk1 ("wr_ack_early", m0_ack,    1'b0);
        step();
        chk1 ("wr_m0_ack",    m0_ack,    1'b1);
        chk1 ("wr_m1_ack",    m1_ack,    1'b0);
        chk1 ("wr_strobe_off", csr_wr,   1'b0);
        m0_req = 0;
        step();
        chk1 ("wr_ack_pulse", m0_ack,    1'b0);
        chk1 ("wr_m1_never",  m1_ack,    1'b0);

        // single read from m1
        m1_req = 1; m1_we = 0; m1_addr = 16'h0020; csr_rdata = 16'h1234;
        step();
        chk1 ("rd_strobe",    csr_rd,    1'b1);
        chk1 ("rd_no_wr",     csr_wr,    1'b0);
        chk16("rd_addr",      csr_addr,  16'h0020);
        step();
        chk1 ("rd_m1_ack",    m1_ack,    1'b1);
        chk1 ("rd_m0_ack",    m0_ack,    1'b0);
        chk16("rd_m1_rdata",  m1_rdata,  16'h1234);
        chk16("rd_m0_rdata",  m0_rdata,  16'h0000);
        m1_req = 0;
        csr_rdata = 16'hDEAD;
        step();
        chk16("rd_m1_hold",   m1_rdata,  16'h1234);

        // simultaneous requests straight after reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk16("rst2_m1_rdata", m1_rdata, 16'h0000);
        m0_req = 1; m0_we = 1; m0_addr = 16'h0030; m0_wdata = 16'h1111;
        m1_req = 1; m1_we = 1; m1_addr = 16'h0040; m1_wdata = 16'h2222;
        for (int c = 1; c <= 12; c++) begin
            step();
            chk1("sim_m0_ack", m0_ack, (c == 2) || (c == 8));
            chk1("sim_m1_ack", m1_ack, (c == 5) || (c == 11));
            chk1("sim_csr_wr", csr_wr, (c == 1) || (c == 4) || (c == 7) || (c == 10));
            if (c == 1 || c == 4 || c == 7 || c == 10) begin
                chk16("sim_addr", csr_addr, (c == 4 || c == 10) ? 16'h0040 : 16'h0030);
            end
            if (c == 11) begin
                m0_req = 0;
                m1_req = 0;
            end
        end

        // lock: m1 locked read then unlocked write while m0 waits
        m1_req = 1; m1_we = 0; m1_lock = 1; m1_addr = 16'h0050; csr_rdata = 16'hBEEF;
        step();
        chk1 ("lk_rd_strobe", csr_rd,   1'b1);
        chk16("lk_rd_addr",   csr_addr, 16'h0050);
        m0_req = 1; m0_we = 1; m0_addr = 16'h0060; m0_wdata = 16'h3333;
        step();
        chk1 ("lk_m1_ack1",   m1_ack,   1'b1);
        chk16("lk_m1_rdata",  m1_rdata, 16'hBEEF);
        step();
        m1_we = 1; m1_lock = 0; m1_addr = 16'h0070; m1_wdata = 16'h4444;
        step();
        chk1 ("lk_wr_strobe", csr_wr,    1'b1);
        chk16("lk_wr_addr",   csr_addr,  16'h0070);
        chk16("lk_wr_wdata",  csr_wdata, 16'h4444);
        step();
        chk1 ("lk_m1_ack2",   m1_ack,   1'b1);
        chk1 ("lk_m0_wait",   m0_ack,   1'b0);
        chk16("lk_rdata_kept", m1_rdata, 16'hBEEF);
        m1_req = 0;
        step();
        step();
        chk16("lk_m0_addr",   csr_addr, 16'h0060);
        chk1 ("lk_m0_strobe", csr_wr,   1'b1);
        step();
        chk1 ("lk_m0_ack",    m0_ack,   1'b1);
        m0_req = 0;
        step();

        // reset during the strobe cycle
        m0_req = 1; m0_we = 0; m0_addr = 16'h0080; csr_rdata = 16'h5555;
        step();
        chk1 ("ra_strobe_on", csr_rd, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1 ("ra_strobe_drop", csr_rd,   1'b0);
        chk16("ra_addr_clr",    csr_addr, 16'h0000);
        chk16("ra_m1_rdata",    m1_rdata, 16'h0000);
        m0_req = 0;
        step();
        chk1 ("ra_no_ack_rst",  m0_ack, 1'b0);
        rst_n = 1'b1;
        step();
        chk1 ("ra_no_ack_m0",   m0_ack, 1'b0);
        chk1 ("ra_no_ack_m1",   m1_ack, 1'b0);
        chk1 ("ra_no_strobe",   csr_rd, 1'b0);
        m0_req = 1; m0_we = 1; m0_addr = 16'h0090; m0_wdata = 16'h0001;
        m1_req = 1; m1_we = 1; m1_addr = 16'h00A0; m1_wdata = 16'h0002;
        step();
        chk1 ("ra_tie_strobe",  csr_wr,   1'b1);
        chk16("ra_tie_addr",    csr_addr, 16'h0090);
        step();
        chk1 ("ra_tie_m0_ack",  m0_ack,   1'b1);
        chk1 ("ra_tie_m1_ack",  m1_ack,   1'b0);
        m0_req = 0; m1_req = 0;
        step();
        step();
        chk16("ra_m0_rdata",    m0_rdata, 16'h0000);
        chk16("ra_m1_rdata2",   m1_rdata, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_csr_io_arbiter
`default_nettype wire
